// File: rtl/dataslot_pkg.sv
// Shared types for the APF target_dataslot command arbiter.
package dataslot_pkg;

  typedef struct packed {
    logic        write;
    logic        halt;
    logic [15:0] id;
    logic [31:0] slotoffset;
    logic [31:0] bridgeaddr;
    logic [31:0] length;
  } dataslot_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } arb_state_t;

  localparam logic [2:0] DS_ERR_TIMEOUT = 3'h7;

endpackage

// File: rtl/dataslot_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap-around.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int          j_int;
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j_int = 0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j_int = int'(ptr) + k;
      if (j_int >= N) j_int = j_int - N;
      j = IW'(j_int);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/dataslot_cmd_arbiter.sv
// Shares the APF target_dataslot command port between NUM_REQ requesters, round-robin.
//
// state        | meaning
// ST_IDLE      | arbitrate; latch winner's command, load timer
// ST_ISSUE     | one setup cycle with fields driven, no strobe
// ST_WAIT_ACK  | read/write strobe high until bridge ack (or timeout)
// ST_WAIT_DONE | waiting for bridge done (or timeout)
// ST_COMPLETE  | one-cycle req_done pulse to the owner
module dataslot_cmd_arbiter
  import dataslot_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd74250000
) (
  input  logic                clk_74a,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  dataslot_cmd_t       req_cmd [NUM_REQ],
  output logic [NUM_REQ-1:0]  req_grant,
  output logic [NUM_REQ-1:0]  req_done,
  output logic [2:0]          req_err [NUM_REQ],
  output logic                target_dataslot_read,
  output logic                target_dataslot_write,
  input  logic                target_dataslot_ack,
  input  logic                target_dataslot_done,
  input  logic [2:0]          target_dataslot_err,
  output logic [15:0]         target_dataslot_id,
  output logic [31:0]         target_dataslot_slotoffset,
  output logic [31:0]         target_dataslot_bridgeaddr,
  output logic [31:0]         target_dataslot_length,
  output logic                processor_halt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  dataslot_cmd_t      cmd_q, cmd_d;
  logic [31:0]        timer_q, timer_d;
  logic [2:0]         err_q, err_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               timer_expire;
  logic               busy;
  logic               complete;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Terminal count: the decrement that lands on zero ends the phase.
  assign timer_expire = (timer_q <= 32'd1);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    timer_d = timer_q;
    err_d   = err_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          cmd_d   = req_cmd[pick_idx];
          idx_d   = pick_idx;
          grant_d = pick_grant;
          timer_d = TIMEOUT_CYCLES;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        timer_d = timer_q - 32'd1;
        if (target_dataslot_done) begin
          err_d   = target_dataslot_err;
          state_d = ST_COMPLETE;
        end else if (target_dataslot_ack) begin
          timer_d = TIMEOUT_CYCLES;
          state_d = ST_WAIT_DONE;
        end else if (timer_expire) begin
          err_d   = DS_ERR_TIMEOUT;
          state_d = ST_COMPLETE;
        end
      end
      ST_WAIT_DONE: begin
        timer_d = timer_q - 32'd1;
        if (target_dataslot_done) begin
          err_d   = target_dataslot_err;
          state_d = ST_COMPLETE;
        end else if (timer_expire) begin
          err_d   = DS_ERR_TIMEOUT;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        rr_d    = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign complete = (state_q == ST_COMPLETE);

  always_comb begin
    req_grant = busy ? grant_q : '0;
    req_done  = complete ? grant_q : '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_err[i] = (complete && grant_q[i]) ? err_q : 3'h0;
    end
  end

  assign target_dataslot_read       = (state_q == ST_WAIT_ACK) && !cmd_q.write;
  assign target_dataslot_write      = (state_q == ST_WAIT_ACK) &&  cmd_q.write;
  assign target_dataslot_id         = cmd_q.id;
  assign target_dataslot_slotoffset = cmd_q.slotoffset;
  assign target_dataslot_bridgeaddr = cmd_q.bridgeaddr;
  assign target_dataslot_length     = cmd_q.length;
  assign processor_halt             = busy && cmd_q.halt;

endmodule
